dmux_sched: RTL
===============

DMUX_SCHED -- requirements
Module: dmux_sched

Interface
REQ-001 Parameter: W, default 4, data width of the input word and of each output channel.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  enable; 1 = accept traffic, 0 = stop accepting and drain.
REQ-005 mode  input  1  0 = fixed routing by sel_cfg, 1 = round-robin routing.
REQ-006 sel_cfg  input  2  target channel in fixed mode (0=a, 1=b, 2=c, 3=d).
REQ-007 in_valid  input  1  input word present.
REQ-008 in_data  input  W  input word.
REQ-009 in_ready  output  1  block can accept in_data this cycle (combinational).
REQ-010 a, b, c, d  output  W each  channel output data, registered.
REQ-011 out_valid  output  4  per-channel valid; bit0=a, bit1=b, bit2=c, bit3=d; registered.
REQ-012 out_ready  input  4  per-channel consumer ready, same bit order.
REQ-013 busy  output  1  1 when state is not IDLE.
REQ-014 acc_cnt  output  8  count of accepted input words, registered.

Function
REQ-015 Accept = in_valid && in_ready; drain[k] = out_valid[k] && out_ready[k].
REQ-016 Target t = sel_cfg when mode=0, ptr when mode=1; ptr is a 2-bit internal register.
REQ-017 Each channel has a one-entry holding register (data + valid bit).
REQ-018 States IDLE, RUN, DRAIN; IDLE->RUN when en=1; RUN->DRAIN when en=0; DRAIN->RUN when en=1; DRAIN->IDLE when en=0 and out_valid==0 at the start of the cycle.
REQ-019 in_ready = (state==RUN) && (!out_valid[t] || out_ready[t]); 0 in IDLE and DRAIN.
REQ-020 On accept, channel t loads in_data and sets its valid at the next edge; latency in->out = 1 cycle.
REQ-021 Accept and drain of the same channel in one cycle: channel stays valid with the new word (no bubble).
REQ-022 Drain without load: channel valid clears and its data register clears to 0.
REQ-023 Channels with out_valid=0 always present data 0.
REQ-024 Channels other than t are unaffected by an accept; independent drains on any channel occur in parallel.
REQ-025 ptr advances by 1 on each accept with mode=1, wrapping 3->0; ptr does not change in mode 0 or without accept.
REQ-026 Changes of mode or sel_cfg take effect on the same cycle's target; no word is lost or duplicated.
REQ-027 acc_cnt increments by 1 per accept, wrapping 255->0.
REQ-028 Words are never dropped: a word held in a channel remains until drained, in any state.

Reset
REQ-029 rst_n=0 asynchronously forces: state=IDLE, ptr=0, out_valid=0, a=b=c=d=0, acc_cnt=0, busy=0; in_ready=0 while in reset.
REQ-030 Reset asserted mid-operation discards all held words; first accept after release requires one edge with en=1 (IDLE->RUN).

Verification
REQ-031 Reset, en=1, mode=0, sel_cfg=2, out_ready=4'hF, in_valid=1, in_data=4'hA -> next cycle c=4'hA, out_valid=4'b0100, acc_cnt=1; a, b, d = 0.
REQ-032 mode=1, out_ready=4'hF, send 5 words 1,2,3,4,5 back-to-back -> land on a,b,c,d,a in order; ptr wraps to 1; acc_cnt=5; in_ready stays 1.
REQ-033 mode=0, sel_cfg=0, out_ready[0]=0, send 2 words -> a holds first word, in_ready=0 for second; raising out_ready[0] with in_valid=1 -> a updates to second word with out_valid[0] continuously 1.
REQ-034 Fill b and d (out_ready=0), drop en -> busy=1, in_ready=0, state DRAIN; release out_ready -> channels clear to 0, next cycle busy=0.
REQ-035 256 accepts -> acc_cnt wraps to 0; rst_n pulsed low asynchronously between clock edges with words held -> all outputs 0 immediately.

Source files
------------

// File: rtl/dmux_sched_if.sv
// Bus bundle for dmux_sched: input word handshake, four output channels, and status.
// master drives traffic and consumer ready; slave is the scheduler itself.
interface dmux_sched_if #(
  parameter int W = 4
);
  logic         en;
  logic         mode;
  logic [1:0]   sel_cfg;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic         busy;
  logic [7:0]   acc_cnt;

  modport master (
    output en, mode, sel_cfg, in_valid, in_data, out_ready,
    input  in_ready, a, b, c, d, out_valid, busy, acc_cnt
  );

  modport slave (
    input  en, mode, sel_cfg, in_valid, in_data, out_ready,
    output in_ready, a, b, c, d, out_valid, busy, acc_cnt
  );
endinterface

// File: rtl/dmux_sched.sv
// One-to-four demultiplexer with a one-entry holding register per channel,
// fixed or round-robin routing, and an IDLE/RUN/DRAIN control FSM.
module dmux_sched #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dmux_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t       r_state;
  logic [1:0]   r_ptr;
  logic [7:0]   r_acc_cnt;
  logic [3:0]   r_valid;
  logic [W-1:0] r_data [4];

  logic [1:0]   w_tgt;
  logic         w_in_ready;
  logic         w_accept;
  logic [3:0]   w_drain;

  assign w_tgt      = bus.mode ? r_ptr : bus.sel_cfg;
  // A full target may still accept when its consumer empties it on the same edge.
  assign w_in_ready = (r_state == RUN) && (!r_valid[w_tgt] || bus.out_ready[w_tgt]);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_drain    = r_valid & bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid[gi] <= 1'b0;
          r_data[gi]  <= '0;
        end else if (w_accept && (w_tgt == 2'(gi))) begin
          r_valid[gi] <= 1'b1;
          r_data[gi]  <= bus.in_data;
        end else if (w_drain[gi]) begin
          r_valid[gi] <= 1'b0;
          r_data[gi]  <= '0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_acc_cnt <= 8'd0;
    end else begin
      if (w_accept) begin
        r_acc_cnt <= r_acc_cnt + 8'd1;
        if (bus.mode) begin
          r_ptr <= r_ptr + 2'd1;
        end
      end
      case (r_state)
        IDLE: begin
          if (bus.en) r_state <= RUN;
        end
        RUN: begin
          if (!bus.en) r_state <= DRAIN;
        end
        DRAIN: begin
          // Leave for IDLE only once every channel was already empty this cycle.
          if (bus.en) begin
            r_state <= RUN;
          end else if (r_valid == 4'd0) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.a         = r_data[0];
  assign bus.b         = r_data[1];
  assign bus.c         = r_data[2];
  assign bus.d         = r_data[3];
  assign bus.busy      = (r_state != IDLE);
  assign bus.acc_cnt   = r_acc_cnt;

endmodule
